// File: rtl/slicer_3d_stream.sv
// slicer_3d_stream: captures a 3D array and streams an offset window out one plane per beat
module slicer_3d_stream #(
  parameter  int I3 = 4,
  parameter  int I2 = 4,
  parameter  int I1 = 8,
  parameter  int O3 = 2,
  parameter  int O2 = 2,
  parameter  int O1 = 2,
  localparam int W3 = (I3 > 1) ? $clog2(I3) : 1,
  localparam int W2 = (I2 > 1) ? $clog2(I2) : 1,
  localparam int W1 = (I1 > 1) ? $clog2(I1) : 1,
  localparam int WI = (O3 > 1) ? $clog2(O3) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [I3-1:0][I2-1:0][I1-1:0]    in_data,
  input  logic [W3-1:0]                    in_off3,
  input  logic [W2-1:0]                    in_off2,
  input  logic [W1-1:0]                    in_off1,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [O2-1:0][O1-1:0]            out_data,
  output logic [WI-1:0]                    out_idx,
  output logic                             out_first,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);
  localparam int J2 = (O2 > 1) ? $clog2(O2) : 1;
  localparam int J1 = (O1 > 1) ? $clog2(O1) : 1;
  localparam int S3 = ((W3 > WI) ? W3 : WI) + 1;
  localparam int S2 = ((W2 > J2) ? W2 : J2) + 1;
  localparam int S1 = ((W1 > J1) ? W1 : J1) + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                        state_q, state_d;
  logic [WI-1:0]                 k_q, k_d;
  logic [I3-1:0][I2-1:0][I1-1:0] data_q, data_d;
  logic [W3-1:0]                 off3_q, off3_d;
  logic [W2-1:0]                 off2_q, off2_d;
  logic [W1-1:0]                 off1_q, off1_d;
  logic [O2-1:0][O1-1:0]         win;
  logic [S3-1:0]                 s3;
  logic                          send, last, fire_out;

  assign send      = state_q == SEND;
  assign last      = k_q == WI'(O3 - 1);
  assign fire_out  = send && out_ready;
  assign out_valid = send;
  assign busy      = send;
  assign out_idx   = k_q;
  assign out_first = send && k_q == '0;
  assign out_last  = send && last;
  assign out_data  = send ? win : '0;

  // Window decode works only from the held copy and k, so in_data never reaches out_data directly.
  assign s3 = S3'(off3_q) + S3'(k_q);
  for (genvar j = 0; j < O2; j++) begin : g_r
    logic [S2-1:0] s2;
    assign s2 = S2'(off2_q) + S2'(j);
    for (genvar b = 0; b < O1; b++) begin : g_b
      logic [S1-1:0] s1;
      assign s1 = S1'(off1_q) + S1'(b);
      assign win[j][b] = (s3 < S3'(I3) && s2 < S2'(I2) && s1 < S1'(I1))
                         ? data_q[s3[W3-1:0]][s2[W2-1:0]][s1[W1-1:0]] : 1'b0;
    end
  end

  // Handshake control: accept when idle or while the final beat leaves, otherwise step k.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    data_d   = data_q;
    off3_d   = off3_q;
    off2_d   = off2_q;
    off1_d   = off1_q;
    in_ready = !send || (fire_out && last);
    if (in_valid && in_ready) begin
      state_d = SEND;
      k_d     = '0;
      data_d  = in_data;
      off3_d  = in_off3;
      off2_d  = in_off2;
      off1_d  = in_off1;
    end else if (fire_out) begin
      state_d = last ? IDLE : SEND;
      k_d     = last ? '0 : k_q + WI'(1);
    end
  end

  // State and holding registers; reset wins over any simultaneous handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      data_q  <= '0;
      off3_q  <= '0;
      off2_q  <= '0;
      off1_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      off3_q  <= off3_d;
      off2_q  <= off2_d;
      off1_q  <= off1_d;
    end
  end
endmodule

// File: tb/tb_slicer_3d_stream.sv
// tb_slicer_3d_stream: directed checks of the streaming 3D window slicer
module tb_slicer_3d_stream;
  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0][3:0][7:0]   din, pat;
  logic [1:0]             off3;
  logic [1:0]             off2;
  logic [2:0]             off1;
  logic                   in_valid, in_ready;
  logic [1:0][1:0]        out_data;
  logic [0:0]             out_idx;
  logic                   out_first, out_last, out_valid, out_ready, busy;
  logic                   b_in_valid, b_in_ready, b_out_first, b_out_last, b_out_valid, b_out_ready, b_busy;
  logic [3:0][7:0]        b_out_data;
  logic [0:0]             b_out_idx;
  int                     checks = 0;
  int                     failures = 0;
  logic [3:0]             bb_exp [6];
  logic [1:0]             bb_o3 [3];
  logic [1:0]             bb_o2 [3];
  logic [2:0]             bb_o1 [3];

  always #5 clk = ~clk;

  slicer_3d_stream dut (
    .clk(clk), .rst(rst), .in_data(din), .in_off3(off3), .in_off2(off2), .in_off1(off1),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_idx(out_idx),
    .out_first(out_first), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  slicer_3d_stream #(.O3(1), .O2(4), .O1(8)) dut_b (
    .clk(clk), .rst(rst), .in_data(din), .in_off3(2'd0), .in_off2(2'd0), .in_off1(3'd0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_idx(b_out_idx),
    .out_first(b_out_first), .out_last(b_out_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        pat[i][j] = 8'(16 * i + j);
    bb_exp = '{4'b0101, 4'b1010, 4'b0100, 4'b0100, 4'b1010, 4'b1111};
    bb_o3 = '{2'd1, 2'd0, 2'd2};
    bb_o2 = '{2'd0, 2'd1, 2'd2};
    bb_o1 = '{3'd4, 3'd1, 3'd4};
    din = pat;
    off3 = '0; off2 = '0; off1 = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    rst = 1'b0;
    step();
    // basic window at (1,1,1); input changes after acceptance must not leak in
    off3 = 2'd1; off2 = 2'd1; off1 = 3'd1; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk("t1_idle_ready", in_ready, 1);
    step();
    in_valid = 1'b0; din = '1; off3 = 2'd3;
    #1;
    chk("t1_k0_valid", out_valid, 1);
    chk("t1_k0_data", out_data, 4'b0100);
    chk("t1_k0_idx", out_idx, 0);
    chk("t1_k0_first", out_first, 1);
    chk("t1_k0_last", out_last, 0);
    chk("t1_k0_ready", in_ready, 0);
    chk("t1_k0_busy", busy, 1);
    step();
    chk("t1_k1_data", out_data, 4'b0100);
    chk("t1_k1_idx", out_idx, 1);
    chk("t1_k1_first", out_first, 0);
    chk("t1_k1_last", out_last, 1);
    chk("t1_k1_ready", in_ready, 1);
    step();
    chk("t1_end_valid", out_valid, 0);
    chk("t1_end_busy", busy, 0);
    // backpressure during k=0 at (1,0,4)
    din = pat; off3 = 2'd1; off2 = 2'd0; off1 = 3'd4; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 4'b0101);
      chk("bp_idx", out_idx, 0);
      chk("bp_first", out_first, 1);
      chk("bp_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_ready", in_ready, 0);
    step();
    chk("bp_k1_data", out_data, 4'b1010);
    chk("bp_k1_last", out_last, 1);
    step();
    chk("bp_end_valid", out_valid, 0);
    // out-of-bounds zero fill at (3,3,7) with an all-ones source
    din = '1; off3 = 2'd3; off2 = 2'd3; off1 = 3'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1 chk("oob_k0_data", out_data, 4'b0001);
    step();
    chk("oob_k1_data", out_data, 4'b0000);
    chk("oob_k1_last", out_last, 1);
    step();
    chk("oob_end_valid", out_valid, 0);
    // three back-to-back transactions, no bubbles
    din = pat; off3 = bb_o3[0]; off2 = bb_o2[0]; off1 = bb_o1[0]; in_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("bb_valid", out_valid, 1);
      chk("bb_data", out_data, bb_exp[n]);
      chk("bb_first", out_first, (n % 2) == 0);
      chk("bb_last", out_last, (n % 2) == 1);
      if (n < 4) begin
        off3 = bb_o3[n / 2 + 1]; off2 = bb_o2[n / 2 + 1]; off1 = bb_o1[n / 2 + 1];
      end
      if (n == 4) in_valid = 1'b0;
    end
    step();
    chk("bb_end_valid", out_valid, 0);
    // reset in the middle of a transaction
    off3 = 2'd0; off2 = 2'd0; off1 = 3'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mr_k0_valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", in_ready, 1);
    step();
    chk("mr_no_k1", out_valid, 0);
    // O3=1 full-plane instance
    din = pat; b_in_valid = 1'b1; b_out_ready = 1'b1;
    step();
    chk("o31_valid", b_out_valid, 1);
    chk("o31_data", b_out_data, 32'h03020100);
    chk("o31_first", b_out_first, 1);
    chk("o31_last", b_out_last, 1);
    chk("o31_idx", b_out_idx, 0);
    chk("o31_ready_hi", b_in_ready, 1);
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    #1;
    chk("o31_ready_lo", b_in_ready, 0);
    chk("o31_hold", b_out_valid, 1);
    b_out_ready = 1'b1;
    step();
    chk("o31_end_valid", b_out_valid, 0);
    chk("o31_end_busy", b_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
